// File: rtl/mac_vec.sv
// rtl/mac_vec.sv - multi-lane saturating multiply-accumulate with vector framing
//
// Each accepted beat multiplies LANES data/weight pairs; stage 2 adds the beat
// sum into a saturating accumulator and emits the dot product on 'last'.
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous, active-high
//   valid      beat present on data/weight/last (no backpressure)
//   last       final beat of the vector, qualified by valid
//   data       LANES x DATA_W, lane i at [i*DATA_W +: DATA_W]
//   weight     LANES x WEIGHT_W, lane i at [i*WEIGHT_W +: WEIGHT_W]
//   out        dot-product result, held until the next result
//   out_valid  one-cycle pulse when out/overflow are new
//   overflow   saturation occurred somewhere in the reported vector
//   busy       partial vector held (accumulated beat or beat in stage 1)
module mac_vec #(
  parameter int LANES    = 4,
  parameter int DATA_W   = 8,
  parameter int WEIGHT_W = 8,
  parameter int ACC_W    = 20,
  parameter int SIGNED   = 0
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         valid,
  input  logic                         last,
  input  logic [LANES*DATA_W-1:0]      data,
  input  logic [LANES*WEIGHT_W-1:0]    weight,
  output logic [ACC_W-1:0]             out,
  output logic                         out_valid,
  output logic                         overflow,
  output logic                         busy
);

  localparam int PW = DATA_W + WEIGHT_W;
  // Beat sum needs ACC_W+clog2(LANES)+1 bits; one more keeps acc+beat_sum exact.
  localparam int SW = ACC_W + $clog2(LANES) + 1;
  localparam int TW = SW + 1;

  localparam logic [ACC_W-1:0] MAX_A = (SIGNED != 0) ? {1'b0, {(ACC_W-1){1'b1}}} : {ACC_W{1'b1}};
  localparam logic [ACC_W-1:0] MIN_A = (SIGNED != 0) ? {1'b1, {(ACC_W-1){1'b0}}} : {ACC_W{1'b0}};
  localparam logic [TW-1:0] ACC_MAX = {{(TW-ACC_W){1'b0}}, MAX_A};
  localparam logic [TW-1:0] ACC_MIN = {{(TW-ACC_W){MIN_A[ACC_W-1]}}, MIN_A};

  logic [PW-1:0] prod_d [LANES];
  logic [PW-1:0] prod_q [LANES];
  logic          s1_valid;
  logic          s1_last;

  logic [ACC_W-1:0] acc;
  logic             acc_active;
  logic             ovf_sticky;

  logic [TW-1:0]    beat_sum;
  logic [TW-1:0]    acc_ext;
  logic [TW-1:0]    total;
  logic [ACC_W-1:0] acc_next;
  logic             sat;

  // Operands are extended to the full product width first; the low PW bits of
  // the product are then exact for both unsigned and two's-complement inputs.
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic [DATA_W-1:0]   d_l;
    logic [WEIGHT_W-1:0] w_l;
    logic [PW-1:0]       d_x;
    logic [PW-1:0]       w_x;
    assign d_l = data[i*DATA_W +: DATA_W];
    assign w_l = weight[i*WEIGHT_W +: WEIGHT_W];
    assign d_x = (SIGNED != 0) ? {{WEIGHT_W{d_l[DATA_W-1]}}, d_l} : {{WEIGHT_W{1'b0}}, d_l};
    assign w_x = (SIGNED != 0) ? {{DATA_W{w_l[WEIGHT_W-1]}}, w_l} : {{DATA_W{1'b0}}, w_l};
    assign prod_d[i] = d_x * w_x;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_last  <= 1'b0;
      for (int i = 0; i < LANES; i++) prod_q[i] <= '0;
    end else begin
      s1_valid <= valid;
      s1_last  <= valid & last;
      if (valid) begin
        for (int i = 0; i < LANES; i++) prod_q[i] <= prod_d[i];
      end
    end
  end

  always_comb begin
    beat_sum = '0;
    for (int i = 0; i < LANES; i++) begin
      if (SIGNED != 0)
        beat_sum = beat_sum + {{(TW-PW){prod_q[i][PW-1]}}, prod_q[i]};
      else
        beat_sum = beat_sum + {{(TW-PW){1'b0}}, prod_q[i]};
    end
    if (SIGNED != 0)
      acc_ext = {{(TW-ACC_W){acc[ACC_W-1]}}, acc};
    else
      acc_ext = {{(TW-ACC_W){1'b0}}, acc};
    total = acc_ext + beat_sum;
    // In unsigned mode total is never negative, so one signed compare serves both modes.
    if ($signed(total) > $signed(ACC_MAX)) begin
      acc_next = MAX_A;
      sat      = 1'b1;
    end else if ($signed(total) < $signed(ACC_MIN)) begin
      acc_next = MIN_A;
      sat      = 1'b1;
    end else begin
      acc_next = total[ACC_W-1:0];
      sat      = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc        <= '0;
      acc_active <= 1'b0;
      ovf_sticky <= 1'b0;
      out        <= '0;
      out_valid  <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      if (s1_valid) begin
        if (s1_last) begin
          out        <= acc_next;
          overflow   <= ovf_sticky | sat;
          out_valid  <= 1'b1;
          acc        <= '0;
          ovf_sticky <= 1'b0;
          acc_active <= 1'b0;
        end else begin
          acc        <= acc_next;
          ovf_sticky <= ovf_sticky | sat;
          acc_active <= 1'b1;
        end
      end
    end
  end

  // acc_active is needed because a partial sum can legitimately be zero.
  assign busy = s1_valid | acc_active;

endmodule

// File: tb/tb_mac_vec.sv
// tb/tb_mac_vec.sv - scoreboard bench for mac_vec, unsigned and signed instances
module tb_mac_vec;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset = 1'b1;
  logic        vin [2];
  logic        lin [2];
  logic [31:0] din [2];
  logic [31:0] win [2];
  logic [19:0] res [2];
  logic        ov  [2];
  logic        ovf [2];
  logic        bsy [2];

  mac_vec #(.LANES(4), .DATA_W(8), .WEIGHT_W(8), .ACC_W(20), .SIGNED(0)) u_dut (
    .clk(clk), .reset(reset), .valid(vin[0]), .last(lin[0]), .data(din[0]), .weight(win[0]),
    .out(res[0]), .out_valid(ov[0]), .overflow(ovf[0]), .busy(bsy[0]));

  mac_vec #(.LANES(4), .DATA_W(8), .WEIGHT_W(8), .ACC_W(20), .SIGNED(1)) s_dut (
    .clk(clk), .reset(reset), .valid(vin[1]), .last(lin[1]), .data(din[1]), .weight(win[1]),
    .out(res[1]), .out_valid(ov[1]), .overflow(ovf[1]), .busy(bsy[1]));

  typedef struct {
    logic [19:0] out;
    bit          ovf;
    int          cyc;
  } exp_t;

  exp_t   q0[$];
  exp_t   q1[$];
  longint m_acc [2];
  bit     m_ovf [2];
  int     cyc = 0;
  int     checks = 0;
  int     errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic longint bsum(bit sgn, logic [31:0] dd, logic [31:0] ww);
    longint s = 0;
    logic [7:0] a, b;
    for (int i = 0; i < 4; i++) begin
      a = dd[i*8 +: 8];
      b = ww[i*8 +: 8];
      if (sgn) s += longint'($signed(a)) * longint'($signed(b));
      else     s += longint'(a) * longint'(b);
    end
    return s;
  endfunction

  task automatic clear_inputs();
    for (int j = 0; j < 2; j++) begin
      vin[j] = 1'b0; lin[j] = 1'b0; din[j] = '0; win[j] = '0;
    end
  endtask

  // One cycle per call: the beat is sampled on the next rising edge and its
  // result (if last) must be seen at the falling edge two cycles later.
  task automatic beat(int k, bit vld, bit lst, logic [31:0] dd, logic [31:0] ww);
    longint t, hi, lo;
    exp_t   e;
    @(posedge clk); #1;
    clear_inputs();
    vin[k] = vld; lin[k] = lst; din[k] = dd; win[k] = ww;
    if (vld) begin
      hi = (k == 1) ? ((longint'(1) << 19) - 1) : ((longint'(1) << 20) - 1);
      lo = (k == 1) ? -(longint'(1) << 19) : 0;
      t = m_acc[k] + bsum(k == 1, dd, ww);
      if (t > hi) begin t = hi; m_ovf[k] = 1'b1; end
      else if (t < lo) begin t = lo; m_ovf[k] = 1'b1; end
      if (lst) begin
        e.out = t[19:0];
        e.ovf = m_ovf[k];
        e.cyc = cyc + 2;
        if (k == 0) q0.push_back(e); else q1.push_back(e);
        m_acc[k] = 0;
        m_ovf[k] = 1'b0;
      end else begin
        m_acc[k] = t;
      end
    end
  endtask

  task automatic idle(int n);
    repeat (n) begin
      @(posedge clk); #1;
      clear_inputs();
    end
  endtask

  task automatic gap_busy(int n);
    repeat (n) begin
      @(posedge clk); #1;
      clear_inputs();
      @(negedge clk);
      chk("busy in gap", bsy[0], 1);
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    clear_inputs();
    reset = 1'b1;
    for (int j = 0; j < 2; j++) begin m_acc[j] = 0; m_ovf[j] = 1'b0; end
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic mon(int k);
    exp_t e;
    if (ov[k]) begin
      if ((k == 0 && q0.size() == 0) || (k == 1 && q1.size() == 0)) begin
        chk(k == 0 ? "u spurious out_valid" : "s spurious out_valid", ov[k], 0);
      end else begin
        e = (k == 0) ? q0.pop_front() : q1.pop_front();
        chk(k == 0 ? "u out" : "s out", res[k], e.out);
        chk(k == 0 ? "u overflow" : "s overflow", ovf[k], e.ovf);
        chk(k == 0 ? "u latency" : "s latency", cyc, e.cyc);
      end
    end
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      mon(0);
      mon(1);
    end
  end

  initial begin
    logic [31:0] dd, ww;
    int          k;
    clear_inputs();
    for (int j = 0; j < 2; j++) begin m_acc[j] = 0; m_ovf[j] = 1'b0; end
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    for (int j = 0; j < 2; j++) begin
      chk("reset out", res[j], 0);
      chk("reset out_valid", ov[j], 0);
      chk("reset overflow", ovf[j], 0);
      chk("reset busy", bsy[j], 0);
    end

    // Basic three-beat vector
    beat(0, 1, 0, 32'h08, 32'h04);
    beat(0, 1, 0, 32'h02, 32'h03);
    beat(0, 1, 1, 32'h01, 32'h02);
    idle(4);

    // Same vector with bubbles
    beat(0, 1, 0, 32'h08, 32'h04);
    gap_busy(3);
    beat(0, 1, 0, 32'h02, 32'h03);
    gap_busy(3);
    beat(0, 1, 1, 32'h01, 32'h02);
    idle(4);
    @(negedge clk);
    chk("busy idle", bsy[0], 0);

    // Unsigned saturation, then clean vector clears overflow
    for (int i = 0; i < 5; i++) beat(0, 1, i == 4, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    beat(0, 1, 1, 32'h01, 32'h01);
    idle(4);

    // Back-to-back single-beat vectors
    beat(0, 1, 1, 32'h03, 32'h03);
    beat(0, 1, 1, 32'h0200, 32'h0500);
    idle(4);

    // Signed mode, small and negative saturation
    beat(1, 1, 0, 32'hFD, 32'h05);
    beat(1, 1, 1, 32'hFF, 32'hFF);
    idle(2);
    for (int i = 0; i < 40; i++) beat(1, 1, i == 39, 32'h8080_8080, 32'h7F7F_7F7F);
    idle(4);

    // Abort mid-vector with reset
    beat(0, 1, 0, 32'h05, 32'h05);
    beat(0, 1, 0, 32'h06, 32'h06);
    do_reset();
    beat(0, 1, 1, 32'h01, 32'h01);
    idle(4);

    // Randomised traffic on both instances
    for (int i = 0; i < 400; i++) begin
      k  = $urandom_range(1, 0);
      dd = $urandom;
      ww = $urandom;
      if ($urandom_range(1, 0) == 1) begin
        dd &= 32'h0F0F_0F0F;
        ww &= 32'h0F0F_0F0F;
      end
      beat(k, $urandom_range(9, 0) < 7, $urandom_range(4, 0) == 0, dd, ww);
    end
    for (int j = 0; j < 2; j++) beat(j, 1, 1, 32'h01, 32'h01);
    idle(6);
    chk("u results drained", q0.size(), 0);
    chk("s results drained", q1.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
